bcd_2_bin: RTL
==============

Name: bcd_2_bin

Overview:
Sequential converter from packed BCD digits to unsigned binary; the inverse of the display-path binary-to-BCD conversion.
- Used where keypad or switch entry arrives in BCD and must become a binary value for arithmetic.
- Iterative multiply-accumulate: one digit per clock, most-significant digit first.
- START/BUSY/DONE handshake toward the controlling logic.

Parameters:
- DIGITS, 4, number of BCD digits in BCD_i.
- BIN_W, 14, width of BIN_o; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 bits hold 9999).

Ports:
- CLK_i  input  1  system clock; all state changes on rising edge.
- RST_i  input  1  synchronous reset, active-high.
- START_i  input  1  request; sampled only in IDLE.
- BCD_i  input  4*DIGITS  packed BCD; digit 0 in [3:0], most-significant digit in [4*DIGITS-1:4*DIGITS-4].
- BUSY_o  output  1  high while a conversion is in progress.
- DONE_o  output  1  one-cycle pulse; BIN_o is valid from this cycle onward.
- BIN_o  output  BIN_W  binary result; holds until the next completion.
- ERR_o  output  1  invalid-digit flag (see Optional Feature).

Interface decision: one clock, CLK_i; reset RST_i is synchronous and active-high.

Behaviour:
- Reset (RST_i=1 at an edge):
  - State=IDLE.
  - BUSY_o=0, DONE_o=0, BIN_o=0, ERR_o=0.
  - Accumulator, shift register and digit counter cleared.
  - Reset wins over START_i and aborts any conversion in flight; no DONE_o is issued for the aborted conversion.
- States: IDLE, CONV.
- IDLE:
  - If START_i=1, capture BCD_i into a shift register, acc<=0, cnt<=DIGITS-1, BUSY_o<=1, go to CONV.
  - DONE_o<=0 in every IDLE cycle without completion.
- CONV, each edge:
  - acc <= acc*10 + top nibble, computed as (acc<<3)+(acc<<1)+nibble, truncated to BIN_W.
  - Shift register moves left 4 bits.
  - cnt decrements.
- Completion: on the edge that processes the last digit (cnt==0):
  - BIN_o <= final value, DONE_o<=1, BUSY_o<=0, state->IDLE.
- Latency: capture edge = edge 0. DONE_o and the new BIN_o are visible in the cycle after edge DIGITS, i.e. DIGITS+1 edges after START_i is sampled (5 for the default).
- START_i while BUSY_o=1 is ignored. No queuing; the in-flight operand is unaffected.
- Changes on BCD_i after the capture edge do not affect the in-flight conversion.
- START_i high during the DONE_o cycle is accepted (state is IDLE), giving back-to-back throughput of one result per DIGITS+1 cycles.
- START_i held high continuously restarts a conversion immediately after each completion.
- Nibble values 0xA-0xF are not rejected. They enter the arithmetic at face value (0xA contributes 10), with no saturation and wrap modulo 2^BIN_W.

Optional Feature:
Macro: BCD_2_BIN_ERR_CHECK_EN.
- Defined:
  - A sticky flag accumulates (nibble > 9) for each digit during CONV; the flag is cleared at the capture edge.
  - At completion, ERR_o <= flag, aligned with DONE_o, and held until the next completion.
  - BIN_o is still written with the raw arithmetic result.
- Undefined:
  - No checking logic is generated.
  - ERR_o is tied to 0.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4 and BCD_DIGIT_MAX=9.
  - State typedef (IDLE, CONV).
  - A function returning the minimum BIN_W for a given DIGITS, used by an elaboration-time parameter check.
- One sub-module, bcd_mac10: combinational acc*10+digit using shift-add, width BIN_W, no multiplier inferred.

Test Plan:
- Reset, then START_i with BCD_i=0x1234 -> BUSY_o high for 4 cycles; DONE_o pulses on cycle 5 after the start sample; BIN_o=1234, ERR_o=0.
- BCD_i=0x9999 then 0x0000 back-to-back (START_i held high across the DONE_o cycle) -> BIN_o=9999, then BIN_o=0 exactly 5 cycles later.
- START_i with 0x0042, then BCD_i changed to 0x7777 and START_i re-pulsed mid-conversion -> single DONE_o, BIN_o=42, second request ignored.
- Start 0x5678, assert RST_i on the 3rd CONV cycle -> all outputs 0 next cycle, no DONE_o pulse. A new start of 0x0001 then gives BIN_o=1.
- With BCD_2_BIN_ERR_CHECK_EN, BCD_i=0x12A4 -> BIN_o=1304, ERR_o=1 with DONE_o. A following 0x0010 gives BIN_o=10, ERR_o=0.
- Without the macro, BCD_i=0x12A4 -> BIN_o=1304, ERR_o=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: digit geometry, FSM state
// type and a helper that computes the smallest binary width holding 10^DIGITS-1.
// No ports; imported by bcd_2_bin_if, bcd_mac10 and bcd_2_bin.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Bits needed to represent the largest DIGITS-digit decimal value.
  // Valid for digits <= 19 (fits a 64-bit unsigned intermediate).
  function automatic int min_bin_w(input int digits);
    longint unsigned max_val;
    int w;
    max_val = 64'd1;
    w       = 0;
    for (int i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    for (int b = 0; b < 64; b++) begin
      if (max_val[b]) begin
        w = b + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_2_bin_if.sv
// Handshake/data bundle between a controller and the BCD-to-binary converter.
// Ports: start/bcd from controller; busy/done/bin/err back from converter.
// master = controlling logic, slave = converter.
interface bcd_2_bin_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          busy;
  logic                          done;
  logic [BIN_W-1:0]              bin;
  logic                          err;

  modport master (
    output start,
    output bcd,
    input  busy,
    input  done,
    input  bin,
    input  err
  );

  modport slave (
    input  start,
    input  bcd,
    output busy,
    output done,
    output bin,
    output err
  );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit via shift-add ((acc<<3)+(acc<<1)+digit), no multiplier.
// Latency: zero (pure combinational). No backpressure; result truncated to BIN_W.
// Ports: acc (BIN_W), digit (4 bits, taken at face value), result (BIN_W).
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result
);

  // All terms are BIN_W wide, so the sum wraps modulo 2^BIN_W.
  assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd_2_bin.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Latency: DONE and BIN appear DIGITS+1 edges after START is sampled in IDLE.
// Backpressure: START is only sampled in IDLE; requests while BUSY are dropped.
// Ports: CLK_i, RST_i (sync, active-high); bus (bcd_2_bin_if.slave): start, bcd in;
//   busy, done, bin, err out.
// Optional: define BCD_2_BIN_ERR_CHECK_EN to flag nibbles above 9 on err; otherwise
//   err is tied low and no checking logic exists.
module bcd_2_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic         CLK_i,
  input  logic         RST_i,
  bcd_2_bin_if.slave   bus
);

  localparam int SH_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Refuse to elaborate if BIN cannot hold the largest decimal input.
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
    $error("bcd_2_bin: BIN_W too small for DIGITS");
  end

  state_t                 state;
  logic [SH_W-1:0]        shreg;
  logic [BIN_W-1:0]       acc;
  logic [CNT_W-1:0]       cnt;
  logic                   busy;
  logic                   done;
  logic [BIN_W-1:0]       bin;

  logic [BCD_DIGIT_W-1:0] nibble;
  logic [BIN_W-1:0]       acc_next;
  logic                   last_digit;

  // The digit being consumed is always the top nibble; the register shifts left.
  assign nibble     = shreg[SH_W-1 -: BCD_DIGIT_W];
  assign last_digit = (cnt == '0);

  bcd_mac10 #(
    .BIN_W (BIN_W)
  ) u_mac10 (
    .acc    (acc),
    .digit  (nibble),
    .result (acc_next)
  );

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            shreg <= bus.bcd;
            acc   <= '0;
            cnt   <= CNT_W'(DIGITS - 1);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          shreg <= shreg << BCD_DIGIT_W;
          cnt   <= cnt - 1'b1;
          if (last_digit) begin
            // acc_next already includes the final digit.
            bin   <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.bin  = bin;

`ifdef BCD_2_BIN_ERR_CHECK_EN
  logic err_flag;
  logic err;
  logic digit_bad;

  assign digit_bad = (nibble > BCD_DIGIT_MAX);

  // err_flag collects bad digits of the conversion in flight; err is the
  // published copy, updated only at completion so it lines up with done.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      err_flag <= 1'b0;
      err      <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        err_flag <= 1'b0;
      end
    end else begin
      err_flag <= err_flag | digit_bad;
      if (last_digit) begin
        err <= err_flag | digit_bad;
      end
    end
  end

  assign bus.err = err;
`else
  assign bus.err = 1'b0;
`endif

endmodule
